// File: rtl/jk_seq_pkg.sv
// Shared opcodes, sequencer states and per-bit JK drive encodings for the
// JK bank sequencer slice.
package jk_seq_pkg;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_CLEAR      = 3'd1;
  localparam logic [2:0] OP_PRESET     = 3'd2;
  localparam logic [2:0] OP_LOAD       = 3'd3;
  localparam logic [2:0] OP_TOGGLE     = 3'd4;
  localparam logic [2:0] OP_COUNT_UP   = 3'd5;
  localparam logic [2:0] OP_COUNT_DOWN = 3'd6;
  localparam logic [2:0] OP_RSVD       = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RUN,
    ST_DONE
  } seq_state_e;

  // Encoded as {j, k}
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

endpackage

// File: rtl/jk_ff_bank.sv
// WIDTH master-slave JK flip-flops. The slave takes the master's value on the
// rising edge, so the bank behaves as edge-triggered JK storage.
module jk_ff_bank
  import jk_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] q_nxt;

  always_comb begin
    q_nxt = q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        JK_RESET:  q_nxt[i] = 1'b0;
        JK_SET:    q_nxt[i] = 1'b1;
        JK_TOGGLE: q_nxt[i] = ~q[i];
        default:   q_nxt[i] = q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= q_nxt;
  end

  assign q_bar = ~q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command sequencer for a JK flip-flop bank: accepts one command at a time and
// drives per-bit J/K vectors for single-step ops or a multi-cycle up/down count.
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  seq_state_e       state, state_nxt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] cnt_vec;
  logic             carry;
  logic             accept;
  logic             is_count;
  logic             count_up;

  assign accept   = cmd_valid & cmd_ready;
  assign is_count = (cmd_op == OP_COUNT_UP) || (cmd_op == OP_COUNT_DOWN);
  assign count_up = (op_r == OP_COUNT_UP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_r   <= OP_NOP;
      data_r <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_r   <= cmd_op;
        data_r <= cmd_data;
        cnt    <= cmd_len;
      end else if (state == ST_RUN) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Ripple-carry toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down)
  always_comb begin
    cnt_vec = '0;
    carry   = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_vec[i] = carry;
      carry      = carry & (count_up ? q[i] : ~q[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    tc        = 1'b0;
    j_out     = '0;
    k_out     = '0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (is_count) state_nxt = (cmd_len == '0) ? ST_DONE : ST_RUN;
          else          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy = 1'b1;
        case (op_r)
          OP_CLEAR:  k_out = '1;
          OP_PRESET: j_out = '1;
          OP_LOAD: begin
            j_out = data_r;
            k_out = ~data_r;
          end
          OP_TOGGLE: begin
            j_out = data_r;
            k_out = data_r;
          end
          default: ;
        endcase
        state_nxt = ST_DONE;
      end
      ST_RUN: begin
        busy  = 1'b1;
        j_out = cnt_vec;
        k_out = cnt_vec;
        tc    = count_up ? (&q) : ~(|q);
        if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  jk_ff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .j     (j_out),
    .k     (k_out),
    .q     (q),
    .q_bar (q_bar)
  );

endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
Controller that sequences a WIDTH-bit bank of master-slave JK flip-flops. It accepts commands over a valid/ready handshake and turns each into per-bit J/K drive vectors: clear, preset, load, toggle-mask, or a multi-cycle synchronous up/down count. The bank reacts to those vectors on the clock edge. The block sits between a command source and the JK storage, and it owns that storage through one instantiated sub-module.

Parameters:
WIDTH, 4, number of JK flip-flops in the bank
CNT_W, 8, width of the count-length field

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_op  input  3  opcode, see Behaviour
cmd_data  input  WIDTH  load value or toggle mask
cmd_len  input  CNT_W  number of count steps (COUNT ops only)
j_out  output  WIDTH  J vector driven to the bank this cycle
k_out  output  WIDTH  K vector driven to the bank this cycle
q  output  WIDTH  bank state
q_bar  output  WIDTH  bitwise complement of q
busy  output  1  high in EXEC, RUN and DONE states
done  output  1  one-cycle pulse on command completion
tc  output  1  terminal count: the coming edge wraps the bank

Behaviour:
- JK rule per bit at each rising edge:
  - j=0,k=0: hold
  - j=0,k=1: q=0
  - j=1,k=0: q=1
  - j=1,k=1: toggle
- Reset (rst_n=0, any time, including mid-command):
  - q=0, q_bar=all ones
  - state=IDLE, cmd_ready=1
  - busy=0, done=0, tc=0, j_out=k_out=0
  - any in-flight command is discarded and no done is issued.
- Opcodes:
  - 0 NOP: j=k=0
  - 1 CLEAR: j=0, k=all ones
  - 2 PRESET: j=all ones, k=0
  - 3 LOAD: j=data, k=~data
  - 4 TOGGLE: j=k=data
  - 5 COUNT_UP
  - 6 COUNT_DOWN
  - 7 reserved, executed as NOP
- States: IDLE, EXEC, RUN, DONE.
- IDLE:
  - j_out=k_out=0; the bank holds.
  - On cmd_valid&cmd_ready, latch op/data/len.
  - COUNT ops go to RUN, or to DONE directly if len==0.
  - All other ops go to EXEC.
- EXEC (1 cycle):
  - Drive the J/K vectors from the latched op.
  - q takes its new value at the closing edge; next state is DONE.
- RUN:
  - A step counter loads len and decrements once per cycle; the state is left when the counter reaches 1, giving exactly len cycles.
  - COUNT_UP: j[i]=k[i]=AND(q[i-1:0]); bit 0 is always 1.
  - COUNT_DOWN: j[i]=k[i]=AND(~q[i-1:0]); bit 0 is always 1.
  - The bank advances by ±1 modulo 2^WIDTH each cycle.
  - tc=1 combinationally during a RUN cycle when q is all ones (UP) or all zeros (DOWN); otherwise 0.
- DONE (1 cycle): done=1, j_out=k_out=0, cmd_ready=0; next state is IDLE.
- cmd_ready is low from the accept edge until DONE exits, so there are no back-to-back accepts.
- Latency:
  - Single-step ops: the op executes in the cycle after acceptance, done appears 1 cycle later, and the next accept is possible 3 cycles after the previous one.
  - COUNT: len cycles in RUN, then DONE.
- cmd_op/cmd_data/cmd_len are ignored outside the accept cycle.
- cmd_len is unsigned. The maximum, 2^CNT_W−1 steps, is legal, and wrap-around past the bank width is repeated and legal.
- q_bar is always exactly ~q; no illegal state exists.

Decomposition:
- Package jk_seq_pkg:
  - opcode localparams (OP_NOP..OP_RSVD)
  - state encoding (ST_IDLE, ST_EXEC, ST_RUN, ST_DONE)
  - JK command constants (hold/reset/set/toggle)
- Sub-module jk_ff_bank (WIDTH param):
  - WIDTH master-slave JK flops with async active-low reset
  - inputs clk, rst_n, j, k; outputs q, q_bar
- The sequencer contains the FSM, step counter and J/K vector generation only.

Test Plan:
- Reset mid-RUN: start COUNT_UP len=10, assert rst_n=0 during step 4 → q=0, state IDLE, no done pulse, cmd_ready=1 after release.
- WIDTH=4, LOAD data=4'hA from reset → in EXEC j_out=1010, k_out=0101; q=4'hA after that edge; done high the next cycle; cmd_ready high the cycle after.
- From q=4'hA, TOGGLE data=4'b0110 → q=4'hC, q_bar=4'h3; then CLEAR → q=0; then PRESET → q=4'hF.
- LOAD 4'hE, then COUNT_UP len=3 → q sequence E,F,0,1; tc=1 only in the cycle q=F; done after 3 RUN cycles; final q=1.
- LOAD 4'h1, then COUNT_DOWN len=2 → q 1,0,F; tc=1 only while q=0. Then COUNT_UP len=0 → straight to DONE, q stays F, no tc.
- cmd_valid held high continuously with changing cmd_data → only the value present in the accept cycle takes effect. Verify cmd_ready is low through EXEC/DONE and opcode 7 behaves as NOP with done.
